pipe_rca: RTL and testbench

Parametrised, pipelined ripple-carry adder/subtractor and the successor to the fixed 4-bit combinational ripple adder. A `WIDTH`-bit operation is split into `NSEG = WIDTH/SEG_W` segments, and each segment is added in its own pipeline stage with a registered carry between stages. It accepts one operation per cycle through a valid/ready handshake with full backpressure and reports sum, carry-out and signed overflow. It sits in datapaths where a wide add would otherwise break timing.

---
 rtl/pipe_rca_pkg.sv | 12 +
 rtl/fa.sv | 11 +
 rtl/rca_seg.sv | 28 ++
 rtl/pipe_rca.sv | 143 ++++++++++++++
 tb/tb_pipe_rca.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_rca_pkg.sv
// Shared configuration helpers for the pipelined ripple-carry adder/subtractor.
package pipe_rca_pkg;

  function automatic int unsigned nseg_f(input int unsigned width, input int unsigned seg_w);
    return width / seg_w;
  endfunction

  function automatic bit cfg_ok_f(input int unsigned width, input int unsigned seg_w);
    return (seg_w != 0) && (width >= seg_w) && ((width % seg_w) == 0);
  endfunction

endpackage

// File: rtl/fa.sv
// One-bit full adder cell.
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/rca_seg.sv
// Combinational SEG_W-bit ripple segment; also exposes the carry into its MSB.
module rca_seg #(
  parameter int unsigned SEG_W = 4
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  output logic [SEG_W-1:0] sum,
  output logic             cout,
  output logic             cmsb
);
  logic [SEG_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SEG_W; i++) begin : g_fa
    fa u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  assign cout = c[SEG_W];
  assign cmsb = c[SEG_W-1];
endmodule

// File: rtl/pipe_rca.sv
// Pipelined ripple-carry adder/subtractor: one SEG_W-bit segment per stage,
// operands skewed forward, completed sum bits deskewed so Sum emerges whole.
module pipe_rca
  import pipe_rca_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SEG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);
  localparam int unsigned NSEG = nseg_f(WIDTH, SEG_W);

  if (!cfg_ok_f(WIDTH, SEG_W)) begin : g_cfg_err
    $error("pipe_rca: WIDTH must be a non-zero multiple of SEG_W");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign b_eff    = Sub ? ~B : B;

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    localparam int unsigned DONE = (k + 1) * SEG_W;
    localparam int unsigned REM  = WIDTH - DONE;

    logic [SEG_W-1:0] seg_a, seg_b, seg_s;
    logic             seg_ci, seg_co, seg_cm, vld_in;
    logic [DONE-1:0]  sum_in, sum_d, sum_q;
    logic             c_d, c_q, vld_d, vld_q;

    if (k == 0) begin : g_head
      assign seg_a  = A[SEG_W-1:0];
      assign seg_b  = b_eff[SEG_W-1:0];
      assign seg_ci = Sub | Cin;
      assign vld_in = in_valid;
      assign sum_in = seg_s;
    end else begin : g_body
      assign seg_a  = g_stage[k-1].g_fwd.a_q[SEG_W-1:0];
      assign seg_b  = g_stage[k-1].g_fwd.b_q[SEG_W-1:0];
      assign seg_ci = g_stage[k-1].c_q;
      assign vld_in = g_stage[k-1].vld_q;
      assign sum_in = {seg_s, g_stage[k-1].sum_q};
    end

    rca_seg #(.SEG_W(SEG_W)) u_seg (
      .a    (seg_a),
      .b    (seg_b),
      .cin  (seg_ci),
      .sum  (seg_s),
      .cout (seg_co),
      .cmsb (seg_cm)
    );

    always_comb begin
      vld_d = vld_q;
      c_d   = c_q;
      sum_d = sum_q;
      if (adv) begin
        vld_d = vld_in;
        c_d   = seg_co;
        sum_d = sum_in;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else begin
        vld_q <= vld_d;
        c_q   <= c_d;
        sum_q <= sum_d;
      end
    end

    if (REM > 0) begin : g_fwd
      // Only the not-yet-added upper operand bits travel on to the next stage.
      logic [REM-1:0] a_src, b_src, a_d, a_q, b_d, b_q;
      logic           cm_unused;

      assign cm_unused = seg_cm;

      if (k == 0) begin : g_src_head
        assign a_src = A[WIDTH-1:SEG_W];
        assign b_src = b_eff[WIDTH-1:SEG_W];
      end else begin : g_src_body
        assign a_src = g_stage[k-1].g_fwd.a_q[SEG_W +: REM];
        assign b_src = g_stage[k-1].g_fwd.b_q[SEG_W +: REM];
      end

      always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (adv) begin
          a_d = a_src;
          b_d = b_src;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end else begin : g_tail
      logic ovf_d, ovf_q;

      always_comb begin
        ovf_d = ovf_q;
        if (adv) ovf_d = seg_co ^ seg_cm;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
      end
    end
  end

  assign out_valid = g_stage[NSEG-1].vld_q;
  assign Sum       = g_stage[NSEG-1].sum_q;
  assign Cout      = g_stage[NSEG-1].c_q;
  assign Ovf       = g_stage[NSEG-1].g_tail.ovf_q;
endmodule

// File: tb/tb_pipe_rca.sv
// Scoreboard bench for pipe_rca: a 16/4 instance (4 stages) and an 8/8 instance (1 stage).
module tb_pipe_rca;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        iv16, ir16, ov16, or16, cin16, sub16, co16, ovf16;
  logic [15:0] a16, b16, s16;
  logic        iv8, ir8, ov8, or8, cin8, sub8, co8, ovf8;
  logic [7:0]  a8, b8, s8;

  pipe_rca #(.WIDTH(16), .SEG_W(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .A(a16), .B(b16),
    .Cin(cin16), .Sub(sub16), .out_valid(ov16), .out_ready(or16), .Sum(s16),
    .Cout(co16), .Ovf(ovf16)
  );

  pipe_rca #(.WIDTH(8), .SEG_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8),
    .Cin(cin8), .Sub(sub8), .out_valid(ov8), .out_ready(or8), .Sum(s8),
    .Cout(co8), .Ovf(ovf8)
  );

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  exp_t q16[$];
  exp_t q8[$];
  int   total = 0;
  int   bad   = 0;

  logic        hold16 = 1'b0;
  logic [15:0] hs16;
  logic        count_en = 1'b0;
  int          lowcnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic issue16(input vec_t v, output int waits);
    logic rdy;
    bit   acc;
    acc   = 0;
    waits = 0;
    a16 = v.a; b16 = v.b; cin16 = v.cin; sub16 = v.sub; iv16 = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      rdy = ir16;
      @(posedge clk);
      if (rdy) begin
        q16.push_back('{sum: v.sum, cout: v.cout, ovf: v.ovf});
        acc = 1;
        break;
      end
      waits++;
    end
    #1 iv16 = 1'b0;
    if (!acc) chk("accept16_timeout", 32'(acc), 32'd1);
  endtask

  task automatic issue8(input vec_t v, output int waits);
    logic rdy;
    bit   acc;
    acc   = 0;
    waits = 0;
    a8 = v.a[7:0]; b8 = v.b[7:0]; cin8 = v.cin; sub8 = v.sub; iv8 = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      rdy = ir8;
      @(posedge clk);
      if (rdy) begin
        q8.push_back('{sum: v.sum, cout: v.cout, ovf: v.ovf});
        acc = 1;
        break;
      end
      waits++;
    end
    #1 iv8 = 1'b0;
    if (!acc) chk("accept8_timeout", 32'(acc), 32'd1);
  endtask

  // Monitors: pop the oldest expectation whenever a result is handed over.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      chk("in_ready16", 32'(ir16), 32'(!ov16 || or16));
      if (ov16 && or16) begin
        chk("q16_nonempty", 32'(q16.size() != 0), 32'd1);
        if (q16.size() != 0) begin
          e = q16.pop_front();
          chk("sum16", 32'(s16), 32'(e.sum));
          chk("cout16", 32'(co16), 32'(e.cout));
          chk("ovf16", 32'(ovf16), 32'(e.ovf));
        end
      end
      if (ov16 && !or16) begin
        if (hold16) chk("hold_sum16", 32'(s16), 32'(hs16));
        hold16 = 1'b1;
        hs16   = s16;
      end else begin
        hold16 = 1'b0;
      end
      if (count_en && !ir16) lowcnt++;
    end else begin
      hold16 = 1'b0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && ov8 && or8) begin
      chk("q8_nonempty", 32'(q8.size() != 0), 32'd1);
      if (q8.size() != 0) begin
        e = q8.pop_front();
        chk("sum8", 32'(s8), 32'(e.sum));
        chk("cout8", 32'(co8), 32'(e.cout));
        chk("ovf8", 32'(ovf8), 32'(e.ovf));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t dir16 [5];
    vec_t str16 [10];
    vec_t rst16 [3];
    vec_t v8    [6];
    int   w, n, wsum;
    bit   found, sawv;

    //              a        b       cin   sub   sum      cout  ovf
    dir16 = '{'{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0},
              '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0},
              '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1},
              '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1},
              '{16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0}};
    str16 = '{'{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0},
              '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0},
              '{16'h1000, 16'h0001, 1'b1, 1'b1, 16'h0FFF, 1'b1, 1'b0},
              '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1},
              '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0},
              '{16'h00F0, 16'h0F0F, 1'b0, 1'b0, 16'h0FFF, 1'b0, 1'b0},
              '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1},
              '{16'hABCD, 16'h1234, 1'b1, 1'b0, 16'hBE02, 1'b0, 1'b0},
              '{16'h0100, 16'h0200, 1'b0, 1'b1, 16'hFF00, 1'b0, 1'b0},
              '{16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1}};
    rst16 = '{'{16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0},
              '{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0},
              '{16'h0003, 16'h0001, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0}};
    v8    = '{'{16'h00C8, 16'h0064, 1'b0, 1'b0, 16'h002C, 1'b1, 1'b0},
              '{16'h0001, 16'h0002, 1'b1, 1'b0, 16'h0004, 1'b0, 1'b0},
              '{16'h007F, 16'h0001, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b1},
              '{16'h0010, 16'h0020, 1'b0, 1'b1, 16'h00F0, 1'b0, 1'b0},
              '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0},
              '{16'h0080, 16'h0001, 1'b1, 1'b1, 16'h007F, 1'b1, 1'b1}};

    rst_n = 1'b0;
    iv16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0; or16 = 1'b1;
    iv8  = 1'b0; a8  = '0; b8  = '0; cin8  = 1'b0; sub8  = 1'b0; or8  = 1'b1;

    #3;
    chk("rst_out_valid16", 32'(ov16), 32'd0);
    chk("rst_sum16", 32'(s16), 32'd0);
    chk("rst_cout16", 32'(co16), 32'd0);
    chk("rst_ovf16", 32'(ovf16), 32'd0);
    chk("rst_out_valid8", 32'(ov8), 32'd0);
    chk("rst_sum8", 32'(s8), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready16", 32'(ir16), 32'd1);
    chk("post_rst_in_ready8", 32'(ir8), 32'd1);
    @(posedge clk);
    #1;

    // First operation: measure latency from the accepting edge.
    issue16(dir16[0], w);
    n = 0;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ov16) begin
        found = 1;
        break;
      end
      @(posedge clk);
      n++;
    end
    chk("lat16_found", 32'(found), 32'd1);
    chk("lat16_edges", 32'(n), 32'd3);
    @(posedge clk);
    #1;

    for (int i = 1; i < 5; i++) issue16(dir16[i], w);

    // Back-to-back stream with a 3-cycle consumer stall.
    lowcnt   = 0;
    count_en = 1'b1;
    fork
      begin
        for (int i = 0; i < 10; i++) issue16(str16[i], w);
      end
      begin
        repeat (4) @(posedge clk);
        #1 or16 = 1'b0;
        repeat (3) @(posedge clk);
        #1 or16 = 1'b1;
      end
    join
    for (int i = 0; i < 30 && q16.size() != 0; i++) @(posedge clk);
    count_en = 1'b0;
    chk("stall_in_ready_low_cycles", 32'(lowcnt), 32'd3);
    chk("stream_drained16", 32'(q16.size()), 32'd0);
    @(posedge clk);
    #1;

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) issue16(rst16[i], w);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid16", 32'(ov16), 32'd0);
    chk("midrst_sum16", 32'(s16), 32'd0);
    chk("midrst_cout16", 32'(co16), 32'd0);
    chk("midrst_ovf16", 32'(ovf16), 32'd0);
    q16.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    sawv = 0;
    @(negedge clk);
    chk("midrst_in_ready16", 32'(ir16), 32'd1);
    if (ov16) sawv = 1;
    repeat (7) begin
      @(negedge clk);
      if (ov16) sawv = 1;
    end
    chk("midrst_no_stale16", 32'(sawv), 32'd0);
    @(posedge clk);
    #1;

    // Single-stage instance: one-cycle latency and full-rate streaming.
    issue8(v8[0], w);
    @(negedge clk);
    chk("lat8_out_valid", 32'(ov8), 32'd1);
    @(posedge clk);
    #1;
    wsum = 0;
    for (int i = 1; i < 6; i++) begin
      issue8(v8[i], w);
      wsum += w;
    end
    chk("rate8_waits", 32'(wsum), 32'd0);

    for (int i = 0; i < 30 && (q16.size() != 0 || q8.size() != 0); i++) @(posedge clk);
    @(negedge clk);
    chk("final_drain16", 32'(q16.size()), 32'd0);
    chk("final_drain8", 32'(q8.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
